// File: rtl/gate3_gates.sv
// Lamp driver for Right/Left built three independent ways (gates, expression, table),
// registered for one-cycle latency, with a sticky flag raised if the three ever disagree.
module gate3_gates (
  input  logic Clock,
  input  logic Resetn,
  input  logic All,
  input  logic Blink,
  output logic Right,
  output logic Left,
  output logic NotBlink,
  output logic Mismatch
);

  // Table path, bit index = {All,Blink}
  localparam logic [3:0] RIGHT_TBL = 4'b1110;
  localparam logic [3:0] LEFT_TBL  = 4'b1101;

  logic w1;
  logic rightG, leftG;
  logic rightE, leftE;
  logic rightT, leftT;
  logic [1:0] sel;

  // Path G: primitives only
  not u_inv   (w1, Blink);
  or  u_or_r  (rightG, All, Blink);
  or  u_or_l  (leftG, All, w1);

  // Path E: kept free of w1 so it stays independent of the gate path
  assign rightE = All | Blink;
  assign leftE  = All | ~Blink;

  assign sel    = {All, Blink};
  assign rightT = RIGHT_TBL[sel];
  assign leftT  = LEFT_TBL[sel];

  logic right_q, left_q, notblink_q, mismatch_q;
  logic right_d, left_d, notblink_d, mismatch_d;
  logic disagree;

  always_comb begin
    disagree   = (rightG != rightE) || (rightG != rightT) ||
                 (leftG  != leftE)  || (leftG  != leftT);
    right_d    = rightG;
    left_d     = leftG;
    notblink_d = w1;
    mismatch_d = mismatch_q | disagree;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      right_q    <= 1'b0;
      left_q     <= 1'b0;
      notblink_q <= 1'b1;
      mismatch_q <= 1'b0;
    end else begin
      right_q    <= right_d;
      left_q     <= left_d;
      notblink_q <= notblink_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign Right    = right_q;
  assign Left     = left_q;
  assign NotBlink = notblink_q;
  assign Mismatch = mismatch_q;

endmodule

// File: tb/tb_gate3_gates.sv
// Directed + random bench for gate3_gates against an arithmetic lamp model.
module tb_gate3_gates;

  logic Clock = 1'b0;
  logic Resetn, All, Blink;
  logic Right, Left, NotBlink, Mismatch;

  int checks = 0;
  int errors = 0;

  gate3_gates dut (
    .Clock(Clock), .Resetn(Resetn), .All(All), .Blink(Blink),
    .Right(Right), .Left(Left), .NotBlink(NotBlink), .Mismatch(Mismatch)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: a lamp is lit when the request count on its side is nonzero.
  function automatic logic m_right(input int a, input int b);
    return ((a + b) != 0);
  endfunction
  function automatic logic m_left(input int a, input int b);
    return ((a + (1 - b)) != 0);
  endfunction

  // Drive inputs, take one edge, sample 1 time unit later and compare.
  task automatic cyc(input string tag, input logic rn, input logic a, input logic b);
    int ai, bi;
    logic er, el, en;
    Resetn = rn; All = a; Blink = b;
    ai = int'(a); bi = int'(b);
    @(posedge Clock);
    #1;
    if (!rn) begin
      er = 1'b0; el = 1'b0; en = 1'b1;
    end else begin
      er = m_right(ai, bi); el = m_left(ai, bi); en = (bi == 0);
    end
    chk({tag, ".Right"},    Right,    er);
    chk({tag, ".Left"},     Left,     el);
    chk({tag, ".NotBlink"}, NotBlink, en);
    chk({tag, ".Mismatch"}, Mismatch, 1'b0);
  endtask

  initial begin
    logic [1:0] combo;
    Resetn = 1'b0; All = 1'b1; Blink = 1'b1;
    #2;

    // Reset held two edges with All=Blink=1
    cyc("rst0", 1'b0, 1'b1, 1'b1);
    cyc("rst1", 1'b0, 1'b1, 1'b1);

    // Exhaustive table
    for (int i = 0; i < 4; i++) begin
      combo = i[1:0];
      cyc($sformatf("tbl%0d", i), 1'b1, combo[1], combo[0]);
    end

    // Blink sequence with All=0, 5 cycles per phase
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 5; k++)
        cyc($sformatf("blink%0d_%0d", p, k), 1'b1, 1'b0, logic'(p % 2));

    // All pulse during Blink=0, then back to idle
    for (int k = 0; k < 4; k++) cyc($sformatf("allp%0d", k), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc($sformatf("allq%0d", k), 1'b1, 1'b0, 1'b0);

    // Mid-operation reset with All=1
    cyc("mid_pre", 1'b1, 1'b1, 1'b0);
    cyc("mid_rst", 1'b0, 1'b1, 1'b0);
    cyc("mid_post", 1'b1, 1'b1, 1'b0);

    // Internal path equivalence for every input combination
    for (int i = 0; i < 4; i++) begin
      combo = i[1:0];
      All = combo[1]; Blink = combo[0];
      #1;
      chk($sformatf("eq%0d.rightG", i), dut.rightG, m_right(int'(combo[1]), int'(combo[0])));
      chk($sformatf("eq%0d.rightE", i), dut.rightE, m_right(int'(combo[1]), int'(combo[0])));
      chk($sformatf("eq%0d.rightT", i), dut.rightT, m_right(int'(combo[1]), int'(combo[0])));
      chk($sformatf("eq%0d.leftG", i),  dut.leftG,  m_left(int'(combo[1]), int'(combo[0])));
      chk($sformatf("eq%0d.leftE", i),  dut.leftE,  m_left(int'(combo[1]), int'(combo[0])));
      chk($sformatf("eq%0d.leftT", i),  dut.leftT,  m_left(int'(combo[1]), int'(combo[0])));
    end

    // Random run; occasional reset pulses
    for (int n = 0; n < 1000; n++)
      cyc($sformatf("rnd%0d", n), ($urandom_range(0, 31) != 0),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate3_gates.md
GATE3_GATES -- requirements
Module: gate3_gates

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 Port Clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 Port Resetn, input, 1 bit: synchronous active-low reset, sampled on the rising Clock edge.
REQ-004 Port All, input, 1 bit: all-lamps-on request.
REQ-005 Port Blink, input, 1 bit: blink phase; 1 selects right side, 0 selects left side.
REQ-006 Port Right, output, 1 bit: registered right lamp drive.
REQ-007 Port Left, output, 1 bit: registered left lamp drive.
REQ-008 Port NotBlink, output, 1 bit: registered copy of the internal inverter output w1.
REQ-009 Port Mismatch, output, 1 bit: sticky flag; set when the internal implementations disagree.
REQ-010 The block SHALL have no parameters; all widths are fixed at 1 bit.

Function
REQ-011 Internal wire w1 SHALL equal NOT Blink and SHALL be produced by a single inverter primitive.
REQ-012 Path G (gate-level) SHALL compute rightG = All OR Blink and leftG = All OR w1, using gate primitives only.
REQ-013 Path E (expression) SHALL compute the same two functions as a continuous Boolean expression, independent of path G.
REQ-014 Path T (table) SHALL compute the same two functions from an explicit 4-entry truth table indexed by {All,Blink}.
REQ-015 Truth table for {All,Blink}: 00 gives Right=0, Left=1; 01 gives Right=1, Left=0; 10 gives Right=1, Left=1; 11 gives Right=1, Left=1.
REQ-016 On each rising Clock edge with Resetn=1, Right, Left and NotBlink SHALL load rightG, leftG and w1 respectively.
REQ-017 Latency from inputs to outputs SHALL be exactly one clock cycle, with no combinational input-to-output path.
REQ-018 On each rising Clock edge with Resetn=1, Mismatch SHALL be set to 1 if any of rightG, rightE, rightT differ or any of leftG, leftE, leftT differ.
REQ-019 Once set, Mismatch SHALL stay at 1 until reset.
REQ-020 In a correct implementation Mismatch SHALL never assert.
REQ-021 The invariant Left = Right = 1 SHALL hold whenever the registered All was 1.
REQ-022 When the registered All was 0, Left SHALL equal NOT Right.
REQ-023 Inputs SHALL be treated as synchronous to Clock; no synchronizers are required.

Reset
REQ-024 When Resetn=0 at a rising Clock edge, the next values SHALL be Right=0, Left=0, NotBlink=1, Mismatch=0, regardless of All and Blink.
REQ-025 Reset SHALL take priority over all other updates, including asserting Mismatch.
REQ-026 On the first edge with Resetn=1, the outputs SHALL reflect the inputs sampled at that edge.
REQ-027 Before the first reset edge, the outputs are unspecified.

Verification
REQ-028 Reset: hold Resetn=0 for 2 edges with All=1, Blink=1 -> Right=0, Left=0, NotBlink=1, Mismatch=0.
REQ-029 Exhaustive table: apply {All,Blink} = 00, 01, 10, 11, one per cycle -> one cycle later (Right,Left) = 01, 10, 11, 11, NotBlink = 1, 0, 1, 0, and Mismatch=0 throughout.
REQ-030 Blink sequence: hold All=0 and toggle Blink 0,1,0,1,0 every 5 cycles -> Right follows Blink and Left follows NOT Blink, each delayed one cycle.
REQ-031 All pulse: All=1 for 4 cycles during Blink=0 -> Right=Left=1 for exactly those 4 cycles (shifted by one), then Right=0, Left=1.
REQ-032 Mid-operation reset: assert Resetn=0 for one edge while All=1 -> that cycle Right=0, Left=0, NotBlink=1; the next cycle Right=1, Left=1.
REQ-033 Equivalence: assert rightG=rightE=rightT and leftG=leftE=leftT for all 4 input combinations, and check Mismatch stays 0 across a 1000-cycle random run.
